// File: rtl/draw_player_if.sv
// -----------------------------------------------------------------------------
// vga_if : video timing + colour bundle passed between drawing stages.
//
// Carries one pixel's timing information and its colour:
//   hcount[10:0], vcount[10:0]  current pixel coordinates
//   hsync, vsync                sync pulses
//   hblnk, vblnk                blanking flags
//   rgb[11:0]                   colour of this pixel
//
// Modports:
//   in   : a stage consuming the stream from the stage upstream of it
//   out  : a stage producing the stream for the stage downstream of it
// -----------------------------------------------------------------------------
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/draw_player.sv
// -----------------------------------------------------------------------------
// draw_player : overlays the 32x32 animated player sprite on the video stream.
//
// The incoming stream (background from the ladder stage) is delayed two pixel
// clocks. In the first cycle the pixel position is tested against the player
// box and a sprite ROM address is registered; the synchronous ROM answers one
// cycle later, and the sprite pixel replaces the background unless it carries
// the transparency colour key.
//
// Player position is sampled once per frame (rising edge of vblnk) so the
// sprite never tears mid-frame. A small walk FSM toggles between two animation
// frames every ANIM_DIV video frames while the player is moving.
//
// Parameters:
//   SPRITE_SIZE  sprite width/height in pixels (only 32 supported)
//   ANIM_DIV     video frames per walk-animation step (1..255)
//   KEY_RGB      transparent colour key in ROM data
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   start_game   enables drawing and animation
//   xpos, ypos   player top-left corner (screen pixels)
//   moving       player is walking
//   dir_left     player faces left (only used with mirroring)
//   rgb_pixel    sprite ROM data, valid one cycle after pixel_addr
//   pixel_addr   sprite ROM address {frame, row[4:0], col[4:0]}
//   in           upstream timing + background (vga_if.in)
//   out          timing + composited colour, 2 cycles later (vga_if.out)
//
// Configuration:
//   PLAYER_MIRROR_EN  when defined, the sprite is drawn horizontally flipped
//                     while the player faces left. When undefined dir_left
//                     is ignored.
// -----------------------------------------------------------------------------
module draw_player #(
  parameter int          SPRITE_SIZE = 32,
  parameter int          ANIM_DIV    = 8,
  parameter logic [11:0] KEY_RGB     = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        moving,
  input  logic        dir_left,
  input  logic [11:0] rgb_pixel,
  output logic [10:0] pixel_addr,
  vga_if.in           in,
  vga_if.out          out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2
  } anim_state_t;

  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  // ---------------------------------------------------------------------------
  // Frame boundary detection and per-frame position capture
  // ---------------------------------------------------------------------------
  logic        r_vblnk_q;
  logic [10:0] r_x_q;
  logic [10:0] r_y_q;
  logic        w_frame_start;

  assign w_frame_start = in.vblnk & ~r_vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_q <= 1'b0;
      r_x_q     <= '0;
      r_y_q     <= '0;
    end else begin
      r_vblnk_q <= in.vblnk;
      if (w_frame_start) begin
        r_x_q <= xpos;
        r_y_q <= ypos;
      end
    end
  end

`ifdef PLAYER_MIRROR_EN
  logic r_dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir_q <= 1'b0;
    end else if (w_frame_start) begin
      r_dir_q <= dir_left;
    end
  end
`else
  // Facing direction has no visible effect when mirroring is not built in.
  logic w_unused_dir;
  assign w_unused_dir = dir_left;
`endif

  // ---------------------------------------------------------------------------
  // Walk animation FSM. Everything advances only at a frame boundary, and the
  // frame bit handed to the address path is the state being entered, so a
  // whole video frame always shows one animation frame.
  // ---------------------------------------------------------------------------
  anim_state_t r_state;
  logic [7:0]  r_anim_cnt;
  logic        r_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_anim_cnt <= '0;
      r_frame    <= 1'b0;
    end else if (!start_game) begin
      // Leaving the game always parks the animation, even on a boundary.
      r_state    <= IDLE;
      r_anim_cnt <= '0;
      r_frame    <= 1'b0;
    end else if (w_frame_start) begin
      case (r_state)
        IDLE: begin
          r_anim_cnt <= '0;
          r_frame    <= 1'b0;
          if (moving) begin
            r_state <= WALK_A;
          end
        end
        WALK_A: begin
          if (!moving) begin
            r_state    <= IDLE;
            r_anim_cnt <= '0;
            r_frame    <= 1'b0;
          end else if (r_anim_cnt == ANIM_LAST) begin
            r_state    <= WALK_B;
            r_anim_cnt <= '0;
            r_frame    <= 1'b1;
          end else begin
            r_anim_cnt <= r_anim_cnt + 8'd1;
            r_frame    <= 1'b0;
          end
        end
        WALK_B: begin
          if (!moving) begin
            r_state    <= IDLE;
            r_anim_cnt <= '0;
            r_frame    <= 1'b0;
          end else if (r_anim_cnt == ANIM_LAST) begin
            r_state    <= WALK_A;
            r_anim_cnt <= '0;
            r_frame    <= 1'b0;
          end else begin
            r_anim_cnt <= r_anim_cnt + 8'd1;
            r_frame    <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_anim_cnt <= '0;
          r_frame    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle 0: box hit test and sprite coordinates.
  // The box end is formed at 12 bits so a sprite near the right/bottom edge
  // does not wrap around and light up pixels at column/row 0.
  // ---------------------------------------------------------------------------
  logic [11:0] w_x_end;
  logic [11:0] w_y_end;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_hit;
  logic [4:0]  w_row;
  logic [4:0]  w_col_off;
  logic [4:0]  w_col;

  assign w_x_end = {1'b0, r_x_q} + 12'(SPRITE_SIZE);
  assign w_y_end = {1'b0, r_y_q} + 12'(SPRITE_SIZE);

  assign w_in_x = (in.hcount >= r_x_q) && ({1'b0, in.hcount} < w_x_end);
  assign w_in_y = (in.vcount >= r_y_q) && ({1'b0, in.vcount} < w_y_end);

  assign w_hit = start_game & ~in.hblnk & ~in.vblnk & w_in_x & w_in_y;

  // Only the low 5 bits of the offsets matter, and they are identical whether
  // the subtraction is done at full or at 5-bit width.
  assign w_row     = in.vcount[4:0] - r_y_q[4:0];
  assign w_col_off = in.hcount[4:0] - r_x_q[4:0];

`ifdef PLAYER_MIRROR_EN
  assign w_col = r_dir_q ? (5'd31 - w_col_off) : w_col_off;
`else
  assign w_col = w_col_off;
`endif

  // ---------------------------------------------------------------------------
  // Two-stage video pipeline. Stage 1 holds the ROM address and the first
  // copy of timing/background; stage 2 lines the hit flag and background up
  // with the ROM data returning from the synchronous sprite ROM.
  // ---------------------------------------------------------------------------
  logic [10:0] r_pixel_addr;
  logic        r_hit_d1;
  logic        r_hit_d2;
  logic [10:0] r_hcount_d1;
  logic [10:0] r_vcount_d1;
  logic        r_hsync_d1;
  logic        r_vsync_d1;
  logic        r_hblnk_d1;
  logic        r_vblnk_d1;
  logic [11:0] r_rgb_d1;
  logic [10:0] r_hcount_d2;
  logic [10:0] r_vcount_d2;
  logic        r_hsync_d2;
  logic        r_vsync_d2;
  logic        r_hblnk_d2;
  logic        r_vblnk_d2;
  logic [11:0] r_rgb_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel_addr <= '0;
      r_hit_d1     <= 1'b0;
      r_hit_d2     <= 1'b0;
      r_hcount_d1  <= '0;
      r_vcount_d1  <= '0;
      r_hsync_d1   <= 1'b0;
      r_vsync_d1   <= 1'b0;
      r_hblnk_d1   <= 1'b0;
      r_vblnk_d1   <= 1'b0;
      r_rgb_d1     <= '0;
      r_hcount_d2  <= '0;
      r_vcount_d2  <= '0;
      r_hsync_d2   <= 1'b0;
      r_vsync_d2   <= 1'b0;
      r_hblnk_d2   <= 1'b0;
      r_vblnk_d2   <= 1'b0;
      r_rgb_d2     <= '0;
    end else begin
      // Outside the box the address is left alone, saving ROM toggling.
      if (w_hit) begin
        r_pixel_addr <= {r_frame, w_row, w_col};
      end
      r_hit_d1    <= w_hit;
      r_hit_d2    <= r_hit_d1;
      r_hcount_d1 <= in.hcount;
      r_vcount_d1 <= in.vcount;
      r_hsync_d1  <= in.hsync;
      r_vsync_d1  <= in.vsync;
      r_hblnk_d1  <= in.hblnk;
      r_vblnk_d1  <= in.vblnk;
      r_rgb_d1    <= in.rgb;
      r_hcount_d2 <= r_hcount_d1;
      r_vcount_d2 <= r_vcount_d1;
      r_hsync_d2  <= r_hsync_d1;
      r_vsync_d2  <= r_vsync_d1;
      r_hblnk_d2  <= r_hblnk_d1;
      r_vblnk_d2  <= r_vblnk_d1;
      r_rgb_d2    <= r_rgb_d1;
    end
  end

  assign pixel_addr = r_pixel_addr;

  assign out.hcount = r_hcount_d2;
  assign out.vcount = r_vcount_d2;
  assign out.hsync  = r_hsync_d2;
  assign out.vsync  = r_vsync_d2;
  assign out.hblnk  = r_hblnk_d2;
  assign out.vblnk  = r_vblnk_d2;

  // Composite: ROM data arrives in this cycle, so the mux is combinational
  // behind registered select/background. The key colour lets the background
  // show through the sprite's transparent pixels.
  assign out.rgb = (r_hit_d2 && (rgb_pixel != KEY_RGB)) ? rgb_pixel : r_rgb_d2;

endmodule

// File: tb/tb_draw_player.sv
// -----------------------------------------------------------------------------
// tb_draw_player : self-checking bench for draw_player.
//
// Drives short synthetic frames (a vblank burst followed by a few scan rows
// around the player box), models the expected ROM address and composited
// output for every driven pixel, queues those expectations, and compares them
// when the DUT produces the corresponding output. A behavioural sprite ROM
// answers pixel_addr one clock later.
// -----------------------------------------------------------------------------
module tb_draw_player;

  localparam int          ANIM_DIV = 8;
  localparam logic [11:0] KEY_RGB  = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_game;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        moving;
  logic        dir_left;
  logic [11:0] rgb_pixel;
  logic [10:0] pixel_addr;

  vga_if vin ();
  vga_if vout ();

  draw_player #(
    .SPRITE_SIZE (32),
    .ANIM_DIV    (ANIM_DIV),
    .KEY_RGB     (KEY_RGB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_game (start_game),
    .xpos       (xpos),
    .ypos       (ypos),
    .moving     (moving),
    .dir_left   (dir_left),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .in         (vin),
    .out        (vout)
  );

  always #5 clk = ~clk;

  // Sprite ROM: column 3 is transparent, column 5 is a flat colour, every
  // other entry is its own address (top bit 0, so it never equals the key).
  function automatic logic [11:0] romData(input logic [10:0] a);
    if (a[4:0] == 5'd3)      return KEY_RGB;
    else if (a[4:0] == 5'd5) return 12'hABC;
    else                     return {1'b0, a};
  endfunction

  always @(posedge clk) rgb_pixel <= romData(pixel_addr);

  int checksPassed = 0;
  int checksTotal  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard queues: address expected one cycle after drive, video two.
  logic [37:0] outQ[$];
  logic [10:0] addrQ[$];

  // Reference model state.
  int          mXq;
  int          mYq;
  logic        mDir;
  int          mState;
  int          mCnt;
  logic        mFrame;
  logic        mVprev;
  logic [10:0] mAddr;

  task automatic modelReset();
    mXq = 0; mYq = 0; mDir = 1'b0;
    mState = 0; mCnt = 0; mFrame = 1'b0;
    mVprev = 1'b0; mAddr = '0;
  endtask

  function automatic logic [37:0] outPacked();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction

  // Called at a falling edge: compare what is due, drive one pixel, predict.
  task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                               input logic hb, input logic vb);
    logic        hs;
    logic        vs;
    logic        boundary;
    logic        hitNow;
    logic [11:0] bg;
    logic [11:0] romv;
    logic [11:0] expRgb;
    logic [4:0]  row;
    logic [4:0]  col;
    int          hi;
    int          vi;

    if (addrQ.size() > 0) checkOutput("pixel_addr", 64'(pixel_addr), 64'(addrQ.pop_front()));
    if (outQ.size() >= 2) checkOutput("out_video", 64'(outPacked()), 64'(outQ.pop_front()));

    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    bg = 12'($urandom_range(0, 4095));
    vin.hcount = h; vin.vcount = v;
    vin.hsync = hs; vin.vsync = vs;
    vin.hblnk = hb; vin.vblnk = vb;
    vin.rgb = bg;

    hi = int'(h);
    vi = int'(v);
    hitNow = start_game && !hb && !vb && (hi >= mXq) && (hi < mXq + 32)
             && (vi >= mYq) && (vi < mYq + 32);
    row = 5'(vi - mYq);
    col = 5'(hi - mXq);
`ifdef PLAYER_MIRROR_EN
    if (mDir) col = 5'd31 - col;
`endif
    if (hitNow) mAddr = {mFrame, row, col};
    addrQ.push_back(mAddr);
    romv   = romData(mAddr);
    expRgb = (hitNow && romv != KEY_RGB) ? romv : bg;
    outQ.push_back({h, v, hs, vs, hb, vb, expRgb});

    boundary = vb && !mVprev;
    mVprev   = vb;
    if (boundary) begin
      mXq = int'(xpos); mYq = int'(ypos); mDir = dir_left;
    end
    if (!start_game) begin
      mState = 0; mCnt = 0; mFrame = 1'b0;
    end else if (boundary) begin
      if (mState == 0) begin
        mCnt = 0;
        if (moving) mState = 1;
      end else if (!moving) begin
        mState = 0; mCnt = 0;
      end else if (mCnt == ANIM_DIV - 1) begin
        mState = (mState == 1) ? 2 : 1; mCnt = 0;
      end else begin
        mCnt++;
      end
      mFrame = (mState == 2);
    end
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    @(negedge clk);
    checkOutput("reset_out", 64'(outPacked()), 64'(0));
    checkOutput("reset_addr", 64'(pixel_addr), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    outQ.delete();
    addrQ.delete();
    outQ.push_back(38'd0);
  endtask

  task automatic frameVblank();
    repeat (3) applyStimulus(11'd0, 11'd770, 1'b1, 1'b1);
  endtask

  task automatic scanRow(input int y, input int xFrom, input int xTo);
    for (int x = xFrom; x <= xTo; x++) applyStimulus(11'(x), 11'(y), 1'b0, 1'b0);
  endtask

  // One frame: vblank, then rows just outside, on, inside and at the far edge
  // of the box, with one horizontally blanked pixel inside the box.
  task automatic runFrame(input int x0, input int y0);
    frameVblank();
    scanRow(y0 - 1, x0 - 1, x0 + 32);
    scanRow(y0, x0 - 1, x0 + 3);
    applyStimulus(11'(x0 + 4), 11'(y0), 1'b1, 1'b0);
    scanRow(y0, x0 + 5, x0 + 32);
    scanRow(y0 + 7, x0 - 1, x0 + 32);
    scanRow(y0 + 31, x0 - 1, x0 + 32);
    scanRow(y0 + 32, x0 - 1, x0 + 32);
  endtask

  // Hit exactly the box origin after a boundary and check the column field.
  task automatic originProbe(input logic [4:0] expCol);
    frameVblank();
    applyStimulus(11'd100, 11'd200, 1'b0, 1'b0);
    checkOutput("origin_col", 64'(pixel_addr[4:0]), 64'(expCol));
    applyStimulus(11'd0, 11'd0, 1'b1, 1'b0);
    applyStimulus(11'd0, 11'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start_game = 1'b0; moving = 1'b0; dir_left = 1'b0;
    xpos = 11'd100; ypos = 11'd200;
    modelReset();
    @(negedge clk);
    applyReset();

    // Game not started: background only.
    runFrame(100, 200);

    start_game = 1'b1;
    runFrame(100, 200);
    runFrame(100, 200);
    originProbe(5'd0);
    checkOutput("origin_addr", 64'(pixel_addr), 64'(0));

    // Walking: 8 frames per animation step, starting from IDLE.
    moving = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      runFrame(100, 200);
      checkOutput("walk_frame_bit", 64'(pixel_addr[10]), 64'(((k - 1) / ANIM_DIV) % 2));
    end
    moving = 1'b0;
    runFrame(100, 200);
    checkOutput("idle_frame_bit", 64'(pixel_addr[10]), 64'(0));

    // Position change mid-frame only takes effect at the next boundary.
    frameVblank();
    xpos = 11'd300;
    scanRow(200, 95, 135);
    scanRow(231, 95, 135);
    checkOutput("hold_col", 64'(pixel_addr[4:0]), 64'(31));
    runFrame(300, 200);

    // Right screen edge: visible columns only, no wrap to column 0.
    xpos = 11'd1010;
    frameVblank();
    scanRow(200, 1000, 1023);
    checkOutput("edge_col", 64'(pixel_addr[4:0]), 64'(13));
    scanRow(200, 0, 5);
    checkOutput("edge_nowrap", 64'(pixel_addr[4:0]), 64'(13));

    // Facing left.
    xpos = 11'd100;
    dir_left = 1'b1;
`ifdef PLAYER_MIRROR_EN
    originProbe(5'd31);
`else
    originProbe(5'd0);
`endif
    runFrame(100, 200);
    dir_left = 1'b0;

    // Dropping start_game mid-walk parks the animation.
    moving = 1'b1;
    runFrame(100, 200);
    runFrame(100, 200);
    frameVblank();
    scanRow(200, 99, 110);
    start_game = 1'b0;
    scanRow(205, 99, 132);
    runFrame(100, 200);
    start_game = 1'b1;
    runFrame(100, 200);
    checkOutput("restart_frame_bit", 64'(pixel_addr[10]), 64'(0));
    moving = 1'b0;

    // Reset in the middle of a frame; positions clear until the next boundary.
    frameVblank();
    scanRow(200, 99, 120);
    applyReset();
    scanRow(0, 0, 3);
    runFrame(100, 200);

    repeat (3) applyStimulus(11'd0, 11'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
